alu_mul_sequencer: RTL and testbench

//  Multi-cycle controller that computes a 32x32 multiply (low 32 bits, RV32 MUL semantics) by sequencing the shared alu

---
 rtl/alu_mul_sequencer_pkg.sv | 23 ++
 rtl/alu_mul_sequencer_alu.sv | 24 ++
 rtl/alu_mul_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared types for the multiply sequencer.
// Provides the ALU op codes and the sequencer state encoding.
package alu_mul_sequencer_pkg;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_PASS_A,
      ALU_SHIFT_LL,
      ALU_SHIFT_RL
   } AluCntrl;

   typedef enum logic [2:0] {
      MUL_IDLE,
      MUL_ADD,
      MUL_SHL,
      MUL_SHR,
      MUL_DONE
   } MulSeqState;

   localparam int MUL_W = 32;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Shared 32-bit ALU slice used by the multiply sequencer.
// Purely combinational; results wrap modulo 2^32 with no flags.
module alu_mul_sequencer_alu
   import alu_mul_sequencer_pkg::*;
(
   input  AluCntrl     alu_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_ADD:      result = in_a + in_b;
         ALU_SUB:      result = in_a - in_b;
         ALU_PASS_A:   result = in_a;
         ALU_SHIFT_LL: result = in_a << in_b[4:0];
         ALU_SHIFT_RL: result = in_a >> in_b[4:0];
         default:      result = '0;
      endcase
   end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiply controller: low 32 bits of a 32x32 product,
// one ALU operation per cycle through ADD/SHL/SHR iterations.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1,
   parameter int ITERS      = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

   MulSeqState  state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [4:0]  iter_q, iter_d;
   logic [31:0] product_q, product_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   AluCntrl     alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_res;

   alu_mul_sequencer_alu u_alu (
      .alu_op (alu_op),
      .in_a   (alu_a),
      .in_b   (alu_b),
      .result (alu_res)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      iter_d    = iter_q;
      product_d = product_q;
      alu_op    = ALU_PASS_A;
      alu_a     = acc_q;
      alu_b     = '0;
      unique case (state_q)
         MUL_IDLE: begin
            if (start) begin
               mcand_d  = multiplicand;
               mplier_d = multiplier;
               acc_d    = '0;
               iter_d   = '0;
               // Zero multiplier skips the ALU entirely; product is known.
               if (EARLY_EXIT && multiplier == '0) begin
                  state_d   = MUL_DONE;
                  product_d = '0;
               end else begin
                  state_d = MUL_ADD;
               end
            end
         end
         MUL_ADD: begin
            alu_op  = mplier_q[0] ? ALU_ADD : ALU_PASS_A;
            alu_a   = acc_q;
            alu_b   = mcand_q;
            acc_d   = alu_res;
            state_d = MUL_SHL;
         end
         MUL_SHL: begin
            alu_op  = ALU_SHIFT_LL;
            alu_a   = mcand_q;
            alu_b   = 32'd1;
            mcand_d = alu_res;
            state_d = MUL_SHR;
         end
         MUL_SHR: begin
            alu_op   = ALU_SHIFT_RL;
            alu_a    = mplier_q;
            alu_b    = 32'd1;
            mplier_d = alu_res;
            iter_d   = iter_q + 5'd1;
            if (iter_q == LAST_ITER ||
                (EARLY_EXIT && alu_res == '0)) begin
               state_d   = MUL_DONE;
               product_d = acc_q;
            end else begin
               state_d = MUL_ADD;
            end
         end
         MUL_DONE: state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
      busy_d = (state_d != MUL_IDLE);
      done_d = (state_d == MUL_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= MUL_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         iter_q    <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         iter_q    <= iter_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer, fixed-latency and
// early-exit instances sharing one clock and reset.
module tb_alu_mul_sequencer;

   logic        clk;
   logic        reset;
   logic        start0, start1;
   logic [31:0] a0, b0, a1, b1;
   logic        busy0, done0, busy1, done1;
   logic [31:0] prod0, prod1;

   int checks;
   int failures;
   logic [31:0] exp_q[$];

   alu_mul_sequencer #(.EARLY_EXIT(1'b0), .ITERS(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start0),
      .multiplicand (a0),
      .multiplier   (b0),
      .busy         (busy0),
      .done         (done0),
      .product      (prod0)
   );

   alu_mul_sequencer #(.EARLY_EXIT(1'b1), .ITERS(32)) dut_ee (
      .clk          (clk),
      .reset        (reset),
      .start        (start1),
      .multiplicand (a1),
      .multiplier   (b1),
      .busy         (busy1),
      .done         (done1),
      .product      (prod1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns latency k where done is seen in cycle T+k, or -1.
   task automatic wait_done(input bit ee, input int budget,
                            output int lat);
      lat = -1;
      for (int k = 1; k <= budget; k++) begin
         if ((ee ? done1 : done0) === 1'b1) begin
            lat = k;
            break;
         end
         tick();
      end
   endtask

   task automatic pop_exp(output logic [31:0] e);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty got=done req=queued_result");
         e = 'x;
      end else begin
         e = exp_q.pop_front();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if (busy0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b req=0", busy0);
      end
      checks++;
      if (done0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%b req=0", done0);
      end
      checks++;
      if (prod0 !== 32'd0) begin
         failures++;
         $display("FAIL reset_product got=%h req=0", prod0);
      end
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_ee got=%b%b req=00", busy1, done1);
      end
   endtask

   task automatic test_basic_timing();
      logic [31:0] e;
      start0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
      exp_q.push_back(32'd15);
      tick();
      start0 = 1'b0; a0 = 32'hdead; b0 = 32'hbeef;
      for (int k = 1; k <= 98; k++) begin
         checks++;
         if (busy0 !== (k <= 97)) begin
            failures++;
            $display("FAIL basic_busy T+%0d got=%b req=%b",
                     k, busy0, (k <= 97));
         end
         checks++;
         if (done0 !== (k == 97)) begin
            failures++;
            $display("FAIL basic_done T+%0d got=%b req=%b",
                     k, done0, (k == 97));
         end
         if (k == 97) begin
            pop_exp(e);
            checks++;
            if (prod0 !== e) begin
               failures++;
               $display("FAIL basic_product got=%h req=%h", prod0, e);
            end
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      logic [31:0] ta[3];
      logic [31:0] tb_[3];
      logic [31:0] e;
      int lat;
      ta[0] = 32'hFFFFFFFF; tb_[0] = 32'd2;
      ta[1] = 32'h00010000; tb_[1] = 32'h00010000;
      ta[2] = 32'hFFFFFFFF; tb_[2] = 32'hFFFFFFFF;
      exp_q.push_back(32'hFFFFFFFE);
      exp_q.push_back(32'h00000000);
      exp_q.push_back(32'h00000001);
      for (int i = 0; i < 3; i++) begin
         start0 = 1'b1; a0 = ta[i]; b0 = tb_[i];
         tick();
         start0 = 1'b0;
         wait_done(1'b0, 150, lat);
         checks++;
         if (lat != 97) begin
            failures++;
            $display("FAIL wrap_latency%0d got=%0d req=97", i, lat);
         end
         if (lat > 0) begin
            pop_exp(e);
            checks++;
            if (prod0 !== e) begin
               failures++;
               $display("FAIL wrap_product%0d got=%h req=%h",
                        i, prod0, e);
            end
         end
         tick();
      end
   endtask

   task automatic test_early_exit();
      logic [31:0] ta[3];
      logic [31:0] tb_[3];
      int tl[3];
      logic [31:0] e;
      int lat;
      ta[0] = 32'd7; tb_[0] = 32'd0; tl[0] = 1;
      ta[1] = 32'd7; tb_[1] = 32'd4; tl[1] = 10;
      ta[2] = 32'd3; tb_[2] = 32'd5; tl[2] = 10;
      for (int i = 0; i < 3; i++) begin
         start1 = 1'b1; a1 = ta[i]; b1 = tb_[i];
         exp_q.push_back(ta[i] * tb_[i]);
         tick();
         start1 = 1'b0;
         wait_done(1'b1, 150, lat);
         checks++;
         if (lat != tl[i]) begin
            failures++;
            $display("FAIL ee_latency%0d got=%0d req=%0d",
                     i, lat, tl[i]);
         end
         if (lat > 0) begin
            pop_exp(e);
            checks++;
            if (prod1 !== e) begin
               failures++;
               $display("FAIL ee_product%0d got=%h req=%h",
                        i, prod1, e);
            end
         end
         tick();
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] e;
      int ndone;
      int done_at;
      ndone = 0;
      done_at = -1;
      start0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
      exp_q.push_back(32'd15);
      tick();
      start0 = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         start0 = (k == 20);
         a0 = 32'd9; b0 = 32'd9;
         if (done0 === 1'b1) begin
            ndone++;
            done_at = k;
            pop_exp(e);
            checks++;
            if (prod0 !== e) begin
               failures++;
               $display("FAIL ignore_product got=%h req=%h", prod0, e);
            end
         end
         tick();
      end
      start0 = 1'b0;
      checks++;
      if (ndone != 1 || done_at != 97) begin
         failures++;
         $display("FAIL ignore_done got=%0d@%0d req=1@97",
                  ndone, done_at);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      int ndone;
      int lat;
      ndone = 0;
      start0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
      exp_q.push_back(32'd15);
      tick();
      start0 = 1'b0;
      for (int k = 1; k < 40; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         failures++;
         $display("FAIL midreset_flags got=%b%b req=00", busy0, done0);
      end
      checks++;
      if (prod0 !== 32'd0) begin
         failures++;
         $display("FAIL midreset_product got=%h req=0", prod0);
      end
      for (int k = 0; k < 110; k++) begin
         if (done0 === 1'b1) ndone++;
         tick();
      end
      checks++;
      if (ndone != 0) begin
         failures++;
         $display("FAIL midreset_no_done got=%0d req=0", ndone);
      end
      start0 = 1'b1; a0 = 32'd2; b0 = 32'd3;
      exp_q.push_back(32'd6);
      tick();
      start0 = 1'b0;
      wait_done(1'b0, 150, lat);
      checks++;
      if (lat != 97) begin
         failures++;
         $display("FAIL midreset_latency got=%0d req=97", lat);
      end
      if (lat > 0) begin
         pop_exp(e);
         checks++;
         if (prod0 !== e) begin
            failures++;
            $display("FAIL midreset_after got=%h req=%h", prod0, e);
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      localparam int N = 5;
      logic [31:0] e;
      int last_k;
      int seen;
      int k;
      last_k = -1;
      seen = 0;
      k = 0;
      a0 = $urandom; b0 = $urandom;
      exp_q.push_back(a0 * b0);
      start0 = 1'b1;
      tick();
      k = 1;
      while (seen < N && k < N * 98 + 50) begin
         if (done0 === 1'b1) begin
            pop_exp(e);
            checks++;
            if (prod0 !== e) begin
               failures++;
               $display("FAIL b2b_product%0d got=%h req=%h",
                        seen, prod0, e);
            end
            if (seen > 0) begin
               checks++;
               if (k - last_k != 98) begin
                  failures++;
                  $display("FAIL b2b_spacing%0d got=%0d req=98",
                           seen, k - last_k);
               end
            end
            last_k = k;
            seen++;
            if (seen < N) begin
               a0 = $urandom; b0 = $urandom;
               exp_q.push_back(a0 * b0);
            end else begin
               start0 = 1'b0;
            end
         end
         tick();
         k++;
      end
      start0 = 1'b0;
      checks++;
      if (seen != N) begin
         failures++;
         $display("FAIL b2b_count got=%0d req=%0d", seen, N);
      end
      tick();
      checks++;
      if (busy0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle got=%b req=0", busy0);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      start0 = 1'b0; start1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      test_reset();
      test_basic_timing();
      test_wrap();
      test_early_exit();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d req=0",
                  exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
